// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant lasts up to MAX_BURST words, and the FIFO full flag stalls it.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              ack,
    input  logic                            fifo_full,
    output logic                            fifo_w_en,
    output logic [DATA_WIDTH-1:0]           fifo_data,
    output logic                            gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0]      gnt_id
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST) + 1;
    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(MAX_BURST - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state_r;
    logic [ID_W-1:0]      gnt_id_r;
    logic [ID_W-1:0]      rr_ptr_r;
    logic [BURST_W-1:0]   burst_cnt_r;
    logic                 gnt_valid_r;

    logic                 fire_s;
    logic [NUM_REQ-1:0]   ack_s;
    logic [ID_W-1:0]      next_ptr_s;
    logic [ID_W-1:0]      pick_s;
    logic [ID_W-1:0]      cand_s;
    logic [DATA_WIDTH-1:0] words_s [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words_s[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Write strobe, one-hot acknowledge and the rotated pointer used on grant exit.
    always_comb begin
        fire_s          = (state_r == BUSY) && req[gnt_id_r] && !fifo_full;
        ack_s           = {NUM_REQ{1'b0}};
        ack_s[gnt_id_r] = fire_s;
        next_ptr_s      = (gnt_id_r == LAST_ID) ? {ID_W{1'b0}} : gnt_id_r + ID_W'(1);
    end

    // Round-robin search; scanning from the far end lets the nearest hit win.
    always_comb begin
        pick_s = rr_ptr_r;
        cand_s = rr_ptr_r;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            pick_s = req[cand_s] ? cand_s : pick_s;
        end
    end

    // Grant state machine: arbitrate in IDLE, stream a bounded burst in BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            gnt_id_r    <= {ID_W{1'b0}};
            rr_ptr_r    <= {ID_W{1'b0}};
            burst_cnt_r <= {BURST_W{1'b0}};
            gnt_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req != {NUM_REQ{1'b0}}) begin
                        gnt_id_r    <= pick_s;
                        burst_cnt_r <= {BURST_W{1'b0}};
                        state_r     <= BUSY;
                        gnt_valid_r <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        gnt_valid_r <= 1'b0;
                    end
                end
                BUSY: begin
                    if (!req[gnt_id_r]) begin
                        state_r     <= IDLE;
                        gnt_valid_r <= 1'b0;
                        rr_ptr_r    <= next_ptr_s;
                    end else if (fire_s) begin
                        burst_cnt_r <= burst_cnt_r + BURST_W'(1);
                        if (burst_cnt_r == LAST_BEAT) begin
                            state_r     <= IDLE;
                            gnt_valid_r <= 1'b0;
                            rr_ptr_r    <= next_ptr_s;
                        end else begin
                            state_r     <= BUSY;
                        end
                    end else begin
                        // FIFO full: hold grant and beat count until space frees up.
                        state_r     <= BUSY;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    gnt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = ack_s;
    assign fifo_w_en = fire_s;
    assign fifo_data = words_s[gnt_id_r];
    assign gnt_valid = gnt_valid_r;
    assign gnt_id    = gnt_id_r;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: arbitration order, bursts, full stalls,
// requester drop, pointer wrap and asynchronous reset mid-burst.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [7:0]  fifo_data;
    logic        gnt_valid;
    logic [1:0]  gnt_id;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .fifo_full(fifo_full), .fifo_w_en(fifo_w_en), .fifo_data(fifo_data),
        .gnt_valid(gnt_valid), .gnt_id(gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [7:0] val);
        req_data[idx*8 +: 8] = val;
    endtask

    // Checks one cycle at the falling edge, then advances to just after the next rising edge.
    task automatic expect_cycle(input string tag, input logic gv, input logic [1:0] gid,
                                input logic [3:0] ack_e, input logic [7:0] data_e);
        @(negedge clk);
        check_eq({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(gv));
        check_eq({tag, ".gnt_id"},    32'(gnt_id),    32'(gid));
        check_eq({tag, ".ack"},       32'(ack),       32'(ack_e));
        check_eq({tag, ".w_en"},      32'(fifo_w_en), 32'(ack_e != 4'b0000));
        if (ack_e != 4'b0000) begin
            check_eq({tag, ".data"}, 32'(fifo_data), 32'(data_e));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        req_data  = 32'h0000_0000;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst.gnt_valid", 32'(gnt_valid), 32'd0);
        check_eq("rst.gnt_id",    32'(gnt_id),    32'd0);
        check_eq("rst.ack",       32'(ack),       32'd0);
        check_eq("rst.w_en",      32'(fifo_w_en), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester: four-word burst, one bubble, then the fifth word.
        req = 4'b0010;
        set_word(1, 8'h11);
        expect_cycle("t1_arb", 1'b0, 2'd0, 4'b0000, 8'h00);
        expect_cycle("t1_w1",  1'b1, 2'd1, 4'b0010, 8'h11);
        set_word(1, 8'h22);
        expect_cycle("t1_w2",  1'b1, 2'd1, 4'b0010, 8'h22);
        set_word(1, 8'h33);
        expect_cycle("t1_w3",  1'b1, 2'd1, 4'b0010, 8'h33);
        set_word(1, 8'h44);
        expect_cycle("t1_w4",  1'b1, 2'd1, 4'b0010, 8'h44);
        set_word(1, 8'h55);
        expect_cycle("t1_bub", 1'b0, 2'd1, 4'b0000, 8'h00);
        expect_cycle("t1_w5",  1'b1, 2'd1, 4'b0010, 8'h55);
        req = 4'b0000;
        expect_cycle("t1_drop", 1'b1, 2'd1, 4'b0000, 8'h00);

        // All four requesting: order 0,1,2,3,0, four words each, one bubble between.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_word(i, 8'hA0 + 8'(i));
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            expect_cycle("t2_bub", 1'b0, (g == 0) ? 2'd0 : 2'((g - 1) % 4), 4'b0000, 8'h00);
            for (int w = 0; w < 4; w++) begin
                expect_cycle("t2_w", 1'b1, 2'(g % 4), 4'(1 << (g % 4)), 8'hA0 + 8'(g % 4));
            end
        end
        req = 4'b0000;

        // Full stall on requester 2 after two writes.
        set_word(2, 8'hC1);
        req = 4'b0100;
        expect_cycle("t3_bub", 1'b0, 2'd0, 4'b0000, 8'h00);
        expect_cycle("t3_w1",  1'b1, 2'd2, 4'b0100, 8'hC1);
        set_word(2, 8'hC2);
        expect_cycle("t3_w2",  1'b1, 2'd2, 4'b0100, 8'hC2);
        set_word(2, 8'hC3);
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) expect_cycle("t3_stall", 1'b1, 2'd2, 4'b0000, 8'h00);
        fifo_full = 1'b0;
        expect_cycle("t3_w3",  1'b1, 2'd2, 4'b0100, 8'hC3);
        set_word(2, 8'hC4);
        expect_cycle("t3_w4",  1'b1, 2'd2, 4'b0100, 8'hC4);
        req = 4'b0000;
        expect_cycle("t3_end", 1'b0, 2'd2, 4'b0000, 8'h00);

        // Requester 3 drops after one write, then re-requests alone.
        set_word(3, 8'hD1);
        req = 4'b1000;
        expect_cycle("t4_bub",  1'b0, 2'd2, 4'b0000, 8'h00);
        expect_cycle("t4_w1",   1'b1, 2'd3, 4'b1000, 8'hD1);
        req = 4'b0000;
        expect_cycle("t4_drop", 1'b1, 2'd3, 4'b0000, 8'h00);
        expect_cycle("t4_idle", 1'b0, 2'd3, 4'b0000, 8'h00);
        set_word(3, 8'hD2);
        req = 4'b1000;
        expect_cycle("t4_bub2", 1'b0, 2'd3, 4'b0000, 8'h00);
        expect_cycle("t4_w2",   1'b1, 2'd3, 4'b1000, 8'hD2);
        req = 4'b0000;
        expect_cycle("t4_drop2", 1'b1, 2'd3, 4'b0000, 8'h00);

        // Short grant to requester 2 leaves the pointer at 3.
        set_word(2, 8'hE0);
        req = 4'b0100;
        expect_cycle("t5_bub",  1'b0, 2'd3, 4'b0000, 8'h00);
        expect_cycle("t5_w",    1'b1, 2'd2, 4'b0100, 8'hE0);
        req = 4'b0000;
        expect_cycle("t5_drop", 1'b1, 2'd2, 4'b0000, 8'h00);

        // Wrap-around: pointer at 3 with req 1001 grants 3, then 0.
        set_word(3, 8'hF3);
        set_word(0, 8'hF0);
        req = 4'b1001;
        expect_cycle("t5_bub2", 1'b0, 2'd2, 4'b0000, 8'h00);
        for (int w = 0; w < 4; w++) expect_cycle("t5_w3", 1'b1, 2'd3, 4'b1000, 8'hF3);
        expect_cycle("t5_bub3", 1'b0, 2'd3, 4'b0000, 8'h00);
        expect_cycle("t5_w0",   1'b1, 2'd0, 4'b0001, 8'hF0);
        req = 4'b0000;
        expect_cycle("t5_drop2", 1'b1, 2'd0, 4'b0000, 8'h00);

        // Asynchronous reset mid-burst of requester 1.
        set_word(1, 8'h61);
        req = 4'b0010;
        expect_cycle("t6_bub", 1'b0, 2'd0, 4'b0000, 8'h00);
        expect_cycle("t6_w1",  1'b1, 2'd1, 4'b0010, 8'h61);
        set_word(1, 8'h62);
        expect_cycle("t6_w2",  1'b1, 2'd1, 4'b0010, 8'h62);
        check_eq("t6_pre.ack", 32'(ack), 32'h2);
        rst = 1'b1;
        #1;
        check_eq("t6_rst.gnt_valid", 32'(gnt_valid), 32'd0);
        check_eq("t6_rst.gnt_id",    32'(gnt_id),    32'd0);
        check_eq("t6_rst.ack",       32'(ack),       32'd0);
        check_eq("t6_rst.w_en",      32'(fifo_w_en), 32'd0);
        req = 4'b0110;
        #1;
        rst = 1'b0;
        expect_cycle("t6_bub2", 1'b0, 2'd0, 4'b0000, 8'h00);
        expect_cycle("t6_w3",   1'b1, 2'd1, 4'b0010, 8'h62);
        req = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of a FIFO among several requesters on the write-clock domain. Each requester presents a word with a request/acknowledge handshake. The arbiter grants one requester at a time for a bounded burst and drives the FIFO `w_en`/`data_in` pair while respecting the FIFO `full` flag. It sits directly in front of the FIFO write side; everything is on one clock.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, default 8: word width; must match the FIFO.
- `MAX_BURST`, default 4: maximum words per grant; legal range 1..16.
- Clocking is fixed: one clock, and reset is asynchronous and active-high.
- `clk`, input, 1: write-domain clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, NUM_REQ: per-requester request; bit i high means word `req_data[i]` is valid.
- `req_data`, input, NUM_REQ*DATA_WIDTH: packed words; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ack`, output, NUM_REQ: one-hot, combinational; bit i high means requester i's word is written this cycle.
- `fifo_full`, input, 1: FIFO full flag.
- `fifo_w_en`, output, 1: FIFO write enable, combinational.
- `fifo_data`, output, DATA_WIDTH: FIFO write data, which is the granted requester's `req_data`.
- `gnt_valid`, output, 1: registered; high while a grant is held (state BUSY).
- `gnt_id`, output, $clog2(NUM_REQ): registered index of the current or last grantee.

## Operation
- States: IDLE and BUSY.
- Registers: `state`, `gnt_id`, `rr_ptr` ($clog2(NUM_REQ)), `burst_cnt` ($clog2(MAX_BURST)+1).
- Fire condition: `fire = (state==BUSY) & req[gnt_id] & ~fifo_full`.
  - `fifo_w_en = fire`.
  - `ack = fire << gnt_id`.
  - `fifo_data = req_data[gnt_id]` whenever BUSY; don't-care in IDLE.
- IDLE, no request: if `req==0`, stay in IDLE.
- IDLE, request pending:
  - Select the first i with `req[i]==1`, searching `rr_ptr, rr_ptr+1, …`, wrapping NUM_REQ-1 to 0.
  - Load `gnt_id<=i`, `burst_cnt<=0`, then go to BUSY.
- BUSY, on fire: `burst_cnt<=burst_cnt+1`.
- BUSY, exit to IDLE when either condition holds:
  - (a) fire occurs with `burst_cnt==MAX_BURST-1`, or
  - (b) `req[gnt_id]==0`.
- On exit: `rr_ptr <= (gnt_id==NUM_REQ-1) ? 0 : gnt_id+1`.
- BUSY, `fifo_full` high with `req[gnt_id]` high: stall.
  - Hold state, grant and `burst_cnt`.
  - No ack, no write, no timeout.
- Requester obligation: hold `req_data` stable while `req` is high and `ack` is low. Dropping `req` without an ack withdraws the word, and no write occurs.
- Requests from non-granted requesters never produce an ack and are ignored until the next IDLE arbitration.
- `fifo_full` is only sampled combinationally. An overflow write is impossible because `fire` masks it in the same cycle.

## Timing
- Reset (asynchronous, while `rst` is high):
  - `state`=IDLE, `rr_ptr`=0, `gnt_id`=0, `burst_cnt`=0.
  - Hence `gnt_valid`=0, `gnt_id`=0, `ack`=0, `fifo_w_en`=0.
- Reset mid-burst: the in-flight grant is abandoned immediately, with no partial write. After release, the first arbitration starts from requester 0.
- Arbitration latency: `req` rising in IDLE at edge N gives BUSY at N+1. The first `ack`/`fifo_w_en` can occur in the cycle after edge N+1.
- Throughput:
  - Within a burst, one word per cycle while not full.
  - One IDLE bubble cycle between consecutive grants.
  - Peak rate is MAX_BURST words per MAX_BURST+1 cycles.
- Burst completion: the last write of a burst and the transition to IDLE happen on the same edge.
- Simultaneous `fifo_full` rise and the last burst word: no fire, so the burst stays open until full clears.
- `gnt_id` holds its last value in IDLE. Consumers use it only when `gnt_valid`=1.

## Test plan
- Reset then single requester: `req=4'b0010`, data 0x11,0x22,0x33,0x44,0x55, full=0.
  - Expect IDLE→BUSY in 1 cycle, then `gnt_id=1` and acks on 4 consecutive cycles writing 0x11..0x44.
  - Expect 1 IDLE cycle, then 0x55 written with `rr_ptr` having advanced to 2.
- All four requesting continuously, MAX_BURST=4: grant order 0,1,2,3,0.
  - Each grant writes exactly 4 words with one bubble between grants.
  - Exactly one `ack` bit is high per fired cycle.
- Full stall: requester 2 granted, `fifo_full` asserted after 2 writes for 5 cycles.
  - Expect zero writes and no acks during the stall, `burst_cnt` held at 2.
  - After full clears, exactly 2 more writes, then the grant ends.
- Requester drop: requester 3 granted, `req[3]` deasserted after 1 write.
  - Expect return to IDLE the next cycle and `rr_ptr=0`.
  - If only `req[3]` then re-asserts, it is granted again.
- Wrap-around priority: `rr_ptr=3`, `req=4'b1001`. Expect requester 3 granted, then requester 0 next.
- Asynchronous reset asserted mid-burst (requester 1, 2 words written): outputs go to reset values immediately without waiting for an edge. After release with `req=4'b0110`, requester 1 is granted first.
